// File: rtl/mult_accumulator.sv
// mult_accumulator: multiply-accumulate back end for the pipelined WIDTH-bit
// array multiplier. The multiplier has no valid or stall, so this block carries
// its own valid/last delay line (WIDTH+1 stages) aligned with the product. It
// sums each vector of products and offers every completed sum with its term
// count on a valid/ready output register.
// Optional build macro: ACC_SAT_EN makes the accumulator saturate at all-ones
// instead of wrapping.
module mult_accumulator #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic                     in_last,
  input  logic [2*WIDTH-1:0]       prod,
  output logic [2*WIDTH+CNT_W-1:0] out_data,
  output logic [CNT_W-1:0]         out_count,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     overrun
);

  localparam int ACC_W = 2*WIDTH + CNT_W;
  localparam int DLY   = WIDTH + 1;

  logic [DLY-1:0]   vld_q, vld_d;
  logic [DLY-1:0]   lst_q, lst_d;
  logic             tail_v, tail_l;
  logic             complete;

  logic             first_q, first_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] acc_base, acc_sum;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [ACC_W-1:0] data_q, data_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;

  // Delay line: shifts every cycle; last is only meaningful with valid.
  always_comb begin
    vld_d = {vld_q[DLY-2:0], in_valid};
    lst_d = {lst_q[DLY-2:0], in_valid & in_last};
  end

  assign tail_v   = vld_q[DLY-1];
  assign tail_l   = lst_q[DLY-1];
  assign complete = tail_v & tail_l;

  // Accumulator input: a new vector starts from zero.
  assign acc_base = first_q ? '0 : acc_q;

`ifdef ACC_SAT_EN
  logic [ACC_W:0] sum_wide;

  // Saturating add: once pinned at all-ones it stays there until completion.
  always_comb begin
    sum_wide = {1'b0, acc_base} + {{(CNT_W+1){1'b0}}, prod};
    acc_sum  = sum_wide[ACC_W] ? '1 : sum_wide[ACC_W-1:0];
  end
`else
  // Wrapping add modulo 2^ACC_W.
  always_comb begin
    acc_sum = acc_base + {{CNT_W{1'b0}}, prod};
  end
`endif

  // Accumulate/count next state; holds on cycles with no valid tail entry.
  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    if (tail_v) begin
      acc_d   = acc_sum;
      first_d = tail_l;
      if (first_q)
        cnt_d = CNT_W'(1);
      else if (cnt_q != '1)
        cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Output register next state: a completion loads when the slot is empty or
  // being drained on this same edge, otherwise it is dropped and flagged.
  always_comb begin
    data_d  = data_q;
    count_d = count_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (valid_q && out_ready)
      valid_d = 1'b0;
    if (complete) begin
      if (!valid_q || out_ready) begin
        data_d  = acc_d;
        count_d = cnt_d;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  // State registers with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q   <= '0;
      lst_q   <= '0;
      first_q <= 1'b1;
      acc_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      vld_q   <= vld_d;
      lst_q   <= lst_d;
      first_q <= first_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      count_q <= count_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign out_data  = data_q;
  assign out_count = count_q;
  assign out_valid = valid_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_mult_accumulator.sv
// Testbench for mult_accumulator: a behavioural pipelined multiplier feeds
// prod; expected results are queued at issue and checked by monitors.
module tb_mult_accumulator;

  localparam int WIDTH  = 4;
  localparam int CNT_W  = 8;
  localparam int ACC_W  = 2*WIDTH + CNT_W;
  localparam int CNT_W2 = 2;
  localparam int ACC_W2 = 2*WIDTH + CNT_W2;
  localparam int LAT    = WIDTH + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic               in_valid, in_last, out_ready;
  logic               in_valid2, in_last2;
  logic [WIDTH-1:0]   a, b;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] mpipe [LAT];

  logic [ACC_W-1:0]   out_data;
  logic [CNT_W-1:0]   out_count;
  logic               out_valid, overrun;
  logic [ACC_W2-1:0]  out_data2;
  logic [CNT_W2-1:0]  out_count2;
  logic               out_valid2, overrun2;

  // Multiplier model: computes a*b every cycle, latency WIDTH+1, no valid.
  always @(posedge clk) begin
    mpipe[0] <= a * b;
    for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  assign prod = mpipe[LAT-1];

  mult_accumulator #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last), .prod(prod),
    .out_data(out_data), .out_count(out_count), .out_valid(out_valid),
    .out_ready(out_ready), .overrun(overrun)
  );

  mult_accumulator #(.WIDTH(WIDTH), .CNT_W(CNT_W2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_last(in_last2), .prod(prod),
    .out_data(out_data2), .out_count(out_count2), .out_valid(out_valid2),
    .out_ready(1'b1), .overrun(overrun2)
  );

  typedef struct packed { logic [CNT_W-1:0]  cnt; logic [ACC_W-1:0]  data; } exp1_t;
  typedef struct packed { logic [CNT_W2-1:0] cnt; logic [ACC_W2-1:0] data; } exp2_t;
  exp1_t q1[$];
  exp2_t q2[$];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor for the main instance: every transfer must match the queue head.
  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (q1.size() == 0) begin
        n_chk++;
        $display("FAIL m1_unexpected: got data %0d count %0d, required no result (t=%0t)",
                 out_data, out_count, $time);
      end else begin
        exp1_t e;
        e = q1.pop_front();
        chk("m1_data", 32'(out_data), 32'(e.data));
        chk("m1_count", 32'(out_count), 32'(e.cnt));
      end
    end
  end

  // Monitor for the narrow-counter instance (always ready).
  always @(negedge clk) begin
    if (out_valid2 === 1'b1) begin
      if (q2.size() == 0) begin
        n_chk++;
        $display("FAIL m2_unexpected: got data %0d count %0d, required no result (t=%0t)",
                 out_data2, out_count2, $time);
      end else begin
        exp2_t e;
        e = q2.pop_front();
        chk("m2_data", 32'(out_data2), 32'(e.data));
        chk("m2_count", 32'(out_count2), 32'(e.cnt));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic v, input logic l, input logic [WIDTH-1:0] av,
                    input logic [WIDTH-1:0] bv);
    in_valid = v;
    in_last  = l;
    a        = av;
    b        = bv;
    tick();
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) op(1'b0, 1'b0, 4'd9, 4'd9);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_valid2 = 1'b0; in_last2 = 1'b0;
    out_ready = 1'b1; a = '0; b = '0;
    repeat (LAT + 2) tick();
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_count", 32'(out_count), 0);
    chk("rst_overrun", 32'(overrun), 0);
    rst = 1'b0;
    tick();

    // Single-term vector 15*15: out_valid only in cycle 6.
    q1.push_back('{cnt: 8'd1, data: 16'd225});
    op(1'b1, 1'b1, 4'd15, 4'd15);
    idle(4);
    chk("single_c5_valid", 32'(out_valid), 0);
    idle(1);
    chk("single_c6_valid", 32'(out_valid), 1);
    chk("single_c6_data", 32'(out_data), 225);
    chk("single_c6_count", 32'(out_count), 1);
    idle(1);
    chk("single_c7_valid", 32'(out_valid), 0);
    idle(2);

    // Back-to-back three terms: 15+14+225=254, result in cycle 8.
    q1.push_back('{cnt: 8'd3, data: 16'd254});
    op(1'b1, 1'b0, 4'd3, 4'd5);
    op(1'b1, 1'b0, 4'd2, 4'd7);
    op(1'b1, 1'b1, 4'd15, 4'd15);
    idle(4);
    chk("three_c7_valid", 32'(out_valid), 0);
    idle(1);
    chk("three_c8_valid", 32'(out_valid), 1);
    chk("three_c8_data", 32'(out_data), 254);
    idle(2);

    // Gapped vector with a stray in_last (no in_valid) in the gap: 16+9.
    q1.push_back('{cnt: 8'd2, data: 16'd25});
    op(1'b1, 1'b0, 4'd4, 4'd4);
    op(1'b0, 1'b1, 4'd9, 4'd9);
    op(1'b0, 1'b0, 4'd9, 4'd9);
    op(1'b1, 1'b1, 4'd3, 4'd3);
    idle(8);

    // Backpressure: second single-term result (4) is dropped.
    out_ready = 1'b0;
    q1.push_back('{cnt: 8'd1, data: 16'd1});
    op(1'b1, 1'b1, 4'd1, 4'd1);
    op(1'b1, 1'b1, 4'd2, 4'd2);
    idle(6);
    chk("bp_valid", 32'(out_valid), 1);
    chk("bp_data", 32'(out_data), 1);
    chk("bp_overrun", 32'(overrun), 1);
    out_ready = 1'b1;
    tick();
    chk("bp_drained", 32'(out_valid), 0);
    idle(8);
    chk("bp_overrun_sticky", 32'(overrun), 1);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_overrun", 32'(overrun), 0);
    chk("rst2_valid", 32'(out_valid), 0);

    // Accept on the exact edge a second result completes.
    out_ready = 1'b0;
    q1.push_back('{cnt: 8'd1, data: 16'd3});
    op(1'b1, 1'b1, 4'd1, 4'd3);
    idle(2);
    q1.push_back('{cnt: 8'd1, data: 16'd6});
    op(1'b1, 1'b1, 4'd2, 4'd3);
    idle(4);
    chk("sim_c8_data", 32'(out_data), 3);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("sim_c9_valid", 32'(out_valid), 1);
    chk("sim_c9_data", 32'(out_data), 6);
    chk("sim_c9_overrun", 32'(overrun), 0);
    idle(2);
    out_ready = 1'b1;
    tick();
    chk("sim_drained", 32'(out_valid), 0);

    // Overflow on the 2-bit counter instance: five terms of 225.
`ifdef ACC_SAT_EN
    q2.push_back('{cnt: 2'd3, data: 10'd1023});
`else
    q2.push_back('{cnt: 2'd3, data: 10'd101});
`endif
    in_valid2 = 1'b1;
    in_last2  = 1'b0;
    for (int i = 0; i < 4; i++) op(1'b0, 1'b0, 4'd15, 4'd15);
    in_last2 = 1'b1;
    op(1'b0, 1'b0, 4'd15, 4'd15);
    in_valid2 = 1'b0;
    in_last2  = 1'b0;
    idle(8);

    // Reset two cycles after presenting a last term: it never emerges.
    op(1'b1, 1'b1, 4'd15, 4'd15);
    idle(1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("rstmid_novalid", 32'(out_valid), 0);
      idle(1);
    end
    q1.push_back('{cnt: 8'd1, data: 16'd2});
    op(1'b1, 1'b1, 4'd1, 4'd2);
    idle(5);
    chk("rstmid_next_valid", 32'(out_valid), 1);
    chk("rstmid_next_data", 32'(out_data), 2);
    chk("rstmid_next_count", 32'(out_count), 1);
    idle(4);

    chk("q1_empty", 32'(q1.size()), 0);
    chk("q2_empty", 32'(q2.size()), 0);
    chk("dut2_overrun", 32'(overrun2), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mult_accumulator.md
Name: mult_accumulator

Overview:
- Downstream consumer of the pipelined n-bit array multiplier. It accumulates a stream of products into a vector sum (dot-product / MAC back end).
- The multiplier has no valid or stall, so this block carries its own valid/last delay line matched to the multiplier latency.
- Each completed sum is presented on a valid/ready output register.
- Sits between the multiplier output `y` and the system result bus.

Parameters:
- WIDTH, 4, operand width of the companion multiplier; product width is 2*WIDTH; multiplier latency is WIDTH+1 cycles.
- CNT_W, 8, term-counter width; accumulator width ACC_W = 2*WIDTH+CNT_W.

Ports:
- clk  in  1  rising-edge clock, shared with the multiplier.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands a/b are being presented to the multiplier this cycle.
- in_last  in  1  qualifies in_valid; marks the final term of a vector.
- prod  in  2*WIDTH  multiplier output y.
- out_data  out  ACC_W  completed vector sum.
- out_count  out  CNT_W  number of terms in out_data.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- overrun  out  1  sticky flag: a result was dropped.

Behaviour:
- **Reset** (rst high at clk edge):
  - Clears the delay line, accumulator, term counter, out_data=0, out_count=0, out_valid=0, overrun=0.
  - Products in flight are discarded.
  - Reset has priority over all other events.
- **Delay line**:
  - in_valid and in_last shift through WIDTH+1 register stages every cycle; there is no stall.
  - The tail entry, tail_v and tail_l, is aligned with prod.
  - Operands presented in cycle 0 give prod and tail valid in cycle WIDTH+1.
- **Accumulate**, in a cycle with tail_v=1:
  - acc <= (first ? 0 : acc) + zero-extended prod.
  - cnt <= first ? 1 : cnt+1.
  - first is set after reset and after every tail_l; it is cleared by any accumulated term.
  - Accumulation wraps modulo 2^ACC_W.
  - cnt saturates at 2^CNT_W-1.
- **Complete**, when tail_v=1 and tail_l=1:
  - The final sum (acc including this prod) and count are offered to the output register.
  - acc and cnt restart on the next term.
  - A single-term vector has out_data=prod.
  - out_valid is asserted in cycle WIDTH+2 relative to operand presentation.
- **Output handshake**:
  - out_valid/out_data/out_count stay stable until out_valid && out_ready.
  - Transfer occurs on that edge; out_valid falls unless a new result is loaded on the same edge.
- **Simultaneous transfer and completion**: the new result loads and out_valid stays 1; no overrun.
- **Completion while out_valid=1 and out_ready=0**:
  - The new result is dropped and overrun is set.
  - Held data is unchanged; overrun clears only on rst.
- tail_v=0 cycles: accumulator state holds.
- in_last without in_valid is ignored.
- Gaps between terms of a vector are allowed.

Optional Feature:
- Macro ACC_SAT_EN.
- Defined: accumulation saturates at 2^ACC_W-1 instead of wrapping. Saturation persists until vector completion; the next vector starts from 0.
- Undefined: modulo-2^ACC_W wrap, with no saturation logic generated.

Test Plan:
- **Single-term vector** (WIDTH=4, out_ready=1): a=15, b=15, in_valid=in_last=1 in cycle 0 -> out_valid=1, out_data=225, out_count=1 in cycle 6, for exactly one cycle.
- **Back-to-back three-term vector**: (3,5), (2,7), (15,15) on consecutive cycles, last on third -> out_data=254, out_count=3, out_valid in cycle 8.
- **Backpressure and overrun**: out_ready=0, two single-term vectors (1,1) then (2,2) -> out_data holds 1 and overrun=1. Raise out_ready -> one transfer of 1; 4 is never presented.
- **Simultaneous accept and complete**: out_ready pulsed exactly on the cycle a second result completes -> second result loads, out_valid stays 1, overrun=0.
- **Overflow** (CNT_W=2, ACC_W=10): five terms of 225, last on fifth:
  - Without ACC_SAT_EN: out_data=101.
  - With ACC_SAT_EN: out_data=1023.
  - In both cases out_count=3 (saturated).
- **Reset mid-vector**: rst asserted 2 cycles after presenting (15,15) with in_last -> no out_valid ever. The next vector (1,2) last -> out_data=2, out_count=1.
